bcd_disp_mux: RTL
=================

Name: bcd_disp_mux

Overview:
- Downstream consumer of the cascaded BCD counter sections.
- Captures the packed BCD digit vector on a load strobe, for example the last section's carry-enable output.
- Time-multiplexes the captured digits onto a common-anode/cathode 7-segment display, with optional leading-zero blanking.
- Scan rate comes from an internal prescaler gated by a clock enable, so the whole block runs on the single system clock with no derived clocks.

Parameters:
- DIGITS, 4, number of BCD digits / anode lines.
- PRESCALE, 16, CLK cycles (with CE=1) per digit slot; must be >= 2.
- DEAD, 1, cycles at the start of each slot with all anodes off (anti-ghosting); 0 <= DEAD < PRESCALE.
- ACTIVE_LOW, 1, 1: SEG and AN active-low; 0: active-high.

Ports:
- CLK, input, 1, system clock, rising edge.
- CLR, input, 1, asynchronous active-high reset.
- CE, input, 1, scan enable; prescaler advances only when 1.
- LOAD, input, 1, snapshot strobe; captures D on the CLK edge.
- D, input, 4*DIGITS, packed BCD; D[3:0] = least significant digit (digit 0).
- BLANK_EN, input, 1, enables leading-zero blanking.
- SEG, output, 7, segments {g,f,e,d,c,b,a}, registered.
- AN, output, DIGITS, one-hot digit select, registered.
- DIG_IDX, output, clog2(DIGITS), current scan index, registered.
- TICK, output, 1, combinational: CE & (P == PRESCALE-1); marks the slot end.

Behaviour:
- Reset (CLR=1, asynchronous, immediate; also mid-scan):
  - SNAP=0, P=0, DIG_IDX=0.
  - AN=all inactive, SEG=all off (inactive level per ACTIVE_LOW).
- Snapshot:
  - LOAD=1 at an edge: SNAP<=D. Otherwise SNAP holds.
  - The display uses only SNAP, never D directly.
- Prescaler P (0..PRESCALE-1):
  - CE=1 and P<PRESCALE-1: P<=P+1.
  - CE=1 and P==PRESCALE-1: P<=0; DIG_IDX<=DIG_IDX+1, wrapping DIGITS-1 -> 0.
  - CE=0: P and DIG_IDX hold; TICK=0.
- Output register, updated every edge regardless of CE:
  - AN/SEG after edge t+1 reflect P, DIG_IDX and SNAP as they stood after edge t (one-cycle pipeline).
  - LOAD at edge e appears on SEG after edge e+1.
- Dead time: if P < DEAD, AN is all inactive and SEG is off.
- Blanking: digit k is blanked when BLANK_EN=1, k != 0, and SNAP digits k..DIGITS-1 are all 0.
  - A blanked digit gets AN inactive and SEG off.
  - Digit 0 is never blanked.
  - A nonzero invalid code (A-F) counts as nonzero and stops blanking.
- Otherwise: AN = one-hot at DIG_IDX, SEG = decode(SNAP digit DIG_IDX).
- Decode table, active-high values (inverted when ACTIVE_LOW=1):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - 10..15 = 40 (dash, segment g only).
- Simultaneous events:
  - LOAD on the same edge as a slot change: the new index shows new SNAP data one edge later, never a mix within a single output update.
  - CE=0 with LOAD: the current digit's SEG updates one cycle after the load.

Test Plan:
(All scenarios use DIGITS=4, PRESCALE=4, DEAD=1, ACTIVE_LOW=0.)
1. CLR pulse mid-slot at DIG_IDX=2 -> same cycle: AN=0000, SEG=00, DIG_IDX=0; after release with CE=1, first TICK 4 cycles later.
2. LOAD with D=16'h1234, CE=1, BLANK_EN=0 -> per 4-cycle slot: 1 dead cycle (AN=0000), then 3 cycles of AN=0001/SEG=66, AN=0010/SEG=4F, AN=0100/SEG=5B, AN=1000/SEG=06; wraps to digit 0; TICK every 4th cycle.
3. BLANK_EN=1, D=16'h0050 -> AN never 0100/1000; digit1 SEG=6D, digit0 SEG=3F. D=16'h0000 -> only AN=0001 with SEG=3F. BLANK_EN=0 with D=16'h0000 -> all four digits show 3F.
4. BLANK_EN=1, D=16'h00A9 -> digit1 SEG=40 (dash, not blanked), digit0 SEG=6F, digits 2-3 blanked.
5. CE=0 for 20 cycles at DIG_IDX=1 -> DIG_IDX, P and AN constant, TICK=0; LOAD D=16'h0070 during the hold -> SEG becomes 07 one cycle after the load edge.
6. LOAD asserted on the same edge as the slot change 1->2, D changing from 16'h1111 to 16'h2222 -> digit2's first active cycle shows SEG=5B; SEG=06 never appears at AN=0100.

Source files
------------

// File: rtl/bcd_disp_mux.sv
// bcd_disp_mux
//   Captures a packed BCD digit vector on LOAD and time-multiplexes the captured
//   digits onto a 7-segment display, with optional leading-zero blanking.
//   The scan rate comes from a CE-gated prescaler, so no derived clocks are used.
//
// Ports
//   CLK      in   system clock, rising edge
//   CLR      in   asynchronous active-high reset
//   CE       in   scan enable; prescaler advances only when high
//   LOAD     in   snapshot strobe; captures D on the clock edge
//   D        in   packed BCD, D[3:0] = digit 0 (least significant)
//   BLANK_EN in   enables leading-zero blanking
//   SEG      out  segments {g,f,e,d,c,b,a}, registered
//   AN       out  one-hot digit select, registered
//   DIG_IDX  out  current scan index, registered
//   TICK     out  combinational slot-end marker: CE & (P == PRESCALE-1)
module bcd_disp_mux #(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned PRESCALE   = 16,
  parameter int unsigned DEAD       = 1,
  parameter bit          ACTIVE_LOW = 1'b1,
  localparam int unsigned IW        = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  CLK,
  input  logic                  CLR,
  input  logic                  CE,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   D,
  input  logic                  BLANK_EN,
  output logic [6:0]            SEG,
  output logic [DIGITS-1:0]     AN,
  output logic [IW-1:0]         DIG_IDX,
  output logic                  TICK
);

  localparam int unsigned        PW       = $clog2(PRESCALE);
  localparam logic [PW-1:0]      P_LAST   = PW'(PRESCALE - 1);
  localparam logic [IW-1:0]      IDX_LAST = IW'(DIGITS - 1);
  // XOR masks that turn active-high values into the pin polarity.
  localparam logic [DIGITS-1:0]  AN_OFF   = {DIGITS{ACTIVE_LOW}};
  localparam logic [6:0]         SEG_OFF  = {7{ACTIVE_LOW}};

  logic [4*DIGITS-1:0] snap_q;
  logic [PW-1:0]       p_q,   p_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q,  an_d;

  logic                slot_end;
  logic                dead;
  logic                blanked;
  logic [3:0]          cur_digit;
  logic [DIGITS-1:0]   nz_from;
  logic [DIGITS-1:0]   an_act;
  logic [6:0]          seg_act;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h40;   // invalid code shows a dash
    endcase
  endfunction

  assign slot_end = CE && (p_q == P_LAST);
  assign TICK     = slot_end;

  // Prescaler and scan index.
  always_comb begin
    p_d   = p_q;
    idx_d = idx_q;
    if (CE) begin
      if (p_q == P_LAST) begin
        p_d   = '0;
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        p_d   = p_q + 1'b1;
      end
    end
  end

  // nz_from[k]: some snapshot digit at position k or above is nonzero.
  // Any nonzero code (including A-F) stops blanking.
  for (genvar k = 0; k < DIGITS; k++) begin : g_nz
    assign nz_from[k] = |snap_q[4*DIGITS-1:4*k];
  end

  if (DEAD == 0) begin : g_nodead
    assign dead = 1'b0;
  end else begin : g_dead
    assign dead = (p_q < PW'(DEAD));
  end

  assign cur_digit = snap_q[{idx_q, 2'b00} +: 4];
  assign blanked   = BLANK_EN && (idx_q != '0) && !nz_from[idx_q];

  // Output stage sees only registered state, giving a one-cycle pipeline.
  always_comb begin
    an_act  = '0;
    seg_act = '0;
    if (!dead && !blanked) begin
      an_act[idx_q] = 1'b1;
      seg_act       = seg_decode(cur_digit);
    end
    an_d  = an_act  ^ AN_OFF;
    seg_d = seg_act ^ SEG_OFF;
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      snap_q <= '0;
      p_q    <= '0;
      idx_q  <= '0;
      an_q   <= AN_OFF;
      seg_q  <= SEG_OFF;
    end else begin
      if (LOAD) begin
        snap_q <= D;
      end
      p_q   <= p_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign SEG     = seg_q;
  assign AN      = an_q;
  assign DIG_IDX = idx_q;

endmodule
